uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The parameter list SHALL be exactly: DATA_WIDTH, 8, frame data bits.
REQ-002 Port CLK  input  1  sole clock; all logic rising-edge triggered.
REQ-003 Port RST  input  1  reset; asynchronous, active-high.
REQ-004 Port RX_IN  input  1  serial line; idle high; already synchronous to CLK.
REQ-005 Port PAR_EN  input  1  1 = parity bit present in frame.
REQ-006 Port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-007 Port Prescale  input  6  CLK cycles per bit; legal values 8, 16, 32 only.
REQ-008 Port P_DATA  output  DATA_WIDTH  last error-free received byte.
REQ-009 Port data_valid  output  1  one-cycle pulse: P_DATA updated with a good frame.
REQ-010 Port par_err  output  1  one-cycle pulse: parity mismatch in finished frame.
REQ-011 Port stp_err  output  1  one-cycle pulse: stop bit sampled 0.

Function
REQ-012 Frame format SHALL be: start (0), DATA_WIDTH data bits LSB first, optional parity, one stop (1).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY skipped when the latched PAR_EN = 0.
REQ-014 PAR_EN, PAR_TYP and Prescale SHALL be latched on the IDLE->START transition and held constant for the whole frame.
REQ-015 IDLE->START SHALL occur on the first cycle RX_IN = 0 in IDLE; edge counter starts at 0 in that cycle.
REQ-016 Edge counter SHALL count 0..Prescale-1 per bit and wrap to 0; bit counter SHALL advance on the wrap.
REQ-017 Each bit value SHALL be the majority of RX_IN at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1.
REQ-018 A sampled start bit of 1 SHALL return the FSM to IDLE at the end of the start-bit period with no output pulse (glitch rejection).
REQ-019 DATA SHALL shift bits into the DATA_WIDTH register LSB first; after bit DATA_WIDTH-1 it SHALL go to PARITY or STOP.
REQ-020 Parity check: even -> XOR(data, parity bit) must be 0; odd -> it must be 1; a mismatch sets an internal flag.
REQ-021 At the end of the STOP bit period, the FSM SHALL return to IDLE and, in the next cycle, pulse exactly one of: data_valid (no errors), or par_err and/or stp_err (any error).
REQ-022 P_DATA SHALL update only together with data_valid and SHALL hold its value otherwise, including on error frames.
REQ-023 Frame latency SHALL be (10 + PAR_EN) x Prescale cycles from start detection to the data_valid pulse with DATA_WIDTH = 8, i.e. 80 cycles for Prescale = 8 with no parity.
REQ-024 Back-to-back frames SHALL be received without loss: RX_IN = 0 in the first IDLE cycle after STOP SHALL start a new frame.
REQ-025 Illegal Prescale values SHALL not hang the FSM; the frame completes with unspecified data.

Reset
REQ-026 RST = 1 SHALL immediately force state IDLE, clear all counters and flags, and set P_DATA = 0, data_valid = 0, par_err = 0 and stp_err = 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; after RST deasserts, reception SHALL resume only on a new falling edge seen in IDLE.

Structure
REQ-028 Package uart_rx_pkg SHALL hold the FSM state enum, the legal Prescale constants (8, 16, 32) and the default DATA_WIDTH.
REQ-029 The edge/bit counters and majority-vote sampler SHALL be one sub-module, uart_rx_sampler, which outputs the sampled bit, a bit_done strobe and the counter values.
REQ-030 The FSM, deserializer, parity/stop checks and output registers SHALL reside in uart_rx.

Verification
REQ-031 Scenario 1: Prescale = 8, PAR_EN = 0, frame carrying byte 0xA5 -> data_valid pulses once at cycle 80 after start and P_DATA = 0xA5.
REQ-032 Scenario 2: Prescale = 16, PAR_EN = 1, PAR_TYP = 0, byte 0x3C with parity 0 -> data_valid pulses and P_DATA = 0x3C; repeat with parity 1 -> par_err pulses and P_DATA is unchanged.
REQ-033 Scenario 3: Prescale = 32, odd parity, byte 0xFF with stop bit = 0 -> stp_err pulses, no data_valid, and P_DATA is unchanged.
REQ-034 Scenario 4: RX_IN low for 2 cycles only (Prescale = 8) -> FSM returns to IDLE with no output pulses; a following valid 0x55 frame is received correctly.
REQ-035 Scenario 5: three back-to-back frames 0x01, 0x80, 0xC3 (Prescale = 8, no parity) -> three data_valid pulses exactly 80 cycles apart with the matching P_DATA values.
REQ-036 Scenario 6: RST asserted during bit 4 of a frame -> outputs are 0 on the same edge, no pulses follow, and the next full frame 0x96 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types, constants and helpers for the UART receiver
package uart_rx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // Unsupported rates fall back to the slowest legal rate so a frame always finishes.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        logic [5:0] r;
        r = PRESCALE_32;
        if (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32) begin
            r = p;
        end
        return r;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit edge/bit counters and 3-point majority-vote sampler
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int BIT_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 rx_in,
    input  logic [5:0]           prescale,
    output logic                 sampled_bit,
    output logic                 bit_done,
    output logic [5:0]           edge_cnt,
    output logic [BIT_CNT_W-1:0] bit_cnt
);

    logic [5:0]           edge_q, edge_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 s0_q, s0_d, s1_q, s1_d, bit_q, bit_d;
    logic [5:0]           mid;
    logic                 at_last;

    assign mid     = {1'b0, prescale[5:1]};
    assign at_last = (edge_q == prescale - 6'd1);

    always_comb begin
        edge_d    = edge_q;
        bit_cnt_d = bit_cnt_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        bit_d     = bit_q;
        if (!enable) begin
            edge_d    = '0;
            bit_cnt_d = '0;
        end else begin
            if (at_last) begin
                edge_d    = '0;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
                edge_d = edge_q + 6'd1;
            end
            if (edge_q == mid - 6'd1) s0_d = rx_in;
            if (edge_q == mid)        s1_d = rx_in;
            if (edge_q == mid + 6'd1) bit_d = majority3(s0_q, s1_q, rx_in);
        end
        // A frame may start in the cycle right after the previous stop bit wrapped.
        if (start) bit_cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q    <= '0;
            bit_cnt_q <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            bit_q     <= 1'b1;
        end else begin
            edge_q    <= edge_d;
            bit_cnt_q <= bit_cnt_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            bit_q     <= bit_d;
        end
    end

    assign sampled_bit = bit_q;
    assign bit_done    = enable & at_last;
    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_cnt_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: frame FSM, deserializer, parity/stop checks, output pulses
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 3);

    state_e                state_q, state_d;
    logic [5:0]            prescale_q, prescale_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  par_flag_q, par_flag_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
    logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;

    logic                  start_det, enable, sampled_bit, bit_done;
    logic [5:0]            edge_cnt, prescale_eff;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    assign start_det    = (state_q == ST_IDLE) && !RX_IN && (edge_cnt == 6'd0);
    assign enable       = (state_q != ST_IDLE) || start_det;
    // The start cycle itself must already count with the new frame's rate.
    assign prescale_eff = start_det ? legal_prescale(Prescale) : prescale_q;

    uart_rx_sampler #(.BIT_CNT_W(BIT_CNT_W)) u_sampler (
        .clk         (CLK),
        .rst         (RST),
        .enable      (enable),
        .start       (start_det),
        .rx_in       (RX_IN),
        .prescale    (prescale_eff),
        .sampled_bit (sampled_bit),
        .bit_done    (bit_done),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt)
    );

    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_flag_d = par_flag_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    state_d    = ST_START;
                    prescale_d = legal_prescale(Prescale);
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_flag_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) state_d = sampled_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt == BIT_CNT_W'(DATA_WIDTH)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    par_flag_d = ((^shift_q) ^ sampled_bit) != par_typ_q;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_d = ST_IDLE;
                    if (par_flag_q || !sampled_bit) begin
                        pe_d = par_flag_q;
                        se_d = !sampled_bit;
                    end else begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            prescale_q <= PRESCALE_8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag_q <= 1'b0;
            shift_q    <= '0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_flag_q <= par_flag_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level reference model
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst, rx, pen, ptyp;
    logic [5:0] presc;
    logic [7:0] pdata;
    logic       dv, pe, se;

    uart_rx dut (
        .CLK        (clk),
        .RST        (rst),
        .RX_IN      (rx),
        .PAR_EN     (pen),
        .PAR_TYP    (ptyp),
        .Prescale   (presc),
        .P_DATA     (pdata),
        .data_valid (dv),
        .par_err    (pe),
        .stp_err    (se)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] exp_pdata = 8'h00;
    int         dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
    int         dv_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Window k is the clock period ending at posedge k; the model says which window carries each pulse.
    always @(negedge clk) begin
        int   k;
        logic edv, epe, ese;
        k   = cyc + 1;
        edv = 1'b0;
        epe = 1'b0;
        ese = 1'b0;
        if (rst) begin
            evq.delete();
            exp_pdata = 8'h00;
        end else if (evq.size() > 0 && evq[0].cyc == k) begin
            edv = evq[0].dv;
            epe = evq[0].pe;
            ese = evq[0].se;
            if (edv) exp_pdata = evq[0].data;
            void'(evq.pop_front());
        end
        check("data_valid", dv, edv);
        check("par_err", pe, epe);
        check("stp_err", se, ese);
        check("P_DATA", pdata, exp_pdata);
        if (dv === 1'b1) begin
            dv_cnt++;
            dv_cyc.push_back(k);
        end
        if (pe === 1'b1) pe_cnt++;
        if (se === 1'b1) se_cnt++;
    end

    // Called #1 after a posedge; leaves the caller #1 after the edge closing the last driven bit.
    task automatic send_frame(input int p, input logic en, input logic typ, input logic [7:0] d,
                              input logic pbit, input logic stopb, input int nbits, output int s);
        logic bits[$];
        ev_t  e;
        logic bad_par;
        int   n;
        bits.push_back(1'b0);
        for (int j = 0; j < 8; j++) bits.push_back(d[j]);
        if (en) bits.push_back(pbit);
        bits.push_back(stopb);
        n       = bits.size();
        presc   = 6'(p);
        pen     = en;
        ptyp    = typ;
        s       = cyc + 1;
        bad_par = en && (((^d) ^ pbit) != typ);
        e.cyc   = s + n * p;
        e.pe    = bad_par;
        e.se    = !stopb;
        e.dv    = !bad_par && stopb;
        e.data  = d;
        evq.push_back(e);
        for (int i = 0; i < n && i < nbits; i++) begin
            rx = bits[i];
            repeat (p) @(posedge clk);
            #1;
            if (i == 0) begin
                presc = (p == 16) ? 6'd8 : 6'd16;
                pen   = !en;
                ptyp  = !typ;
            end
        end
        rx = 1'b1;
    endtask

    int s, s1, s2, s3, last_dv, d1, d2;

    initial begin
        rst   = 1'b1;
        rx    = 1'b1;
        pen   = 1'b0;
        ptyp  = 1'b0;
        presc = 6'd8;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pdata", pdata, 8'h00);
        check("reset_pulses", {dv, pe, se}, 3'b000);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 99, s);
        repeat (5) @(posedge clk);
        #1;
        last_dv = (dv_cyc.size() > 0) ? dv_cyc[dv_cyc.size()-1] : -1;
        check("s1_dv_count", dv_cnt, 1);
        check("s1_latency", last_dv - s, 80);
        check("s1_pdata", pdata, 8'hA5);

        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 99, s);
        repeat (5) @(posedge clk);
        #1;
        check("s2_good_pdata", pdata, 8'h3C);
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 99, s);
        repeat (5) @(posedge clk);
        #1;
        check("s2_par_err_count", pe_cnt, 1);
        check("s2_dv_count", dv_cnt, 2);

        send_frame(32, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 99, s);
        repeat (5) @(posedge clk);
        #1;
        check("s3_stp_err_count", se_cnt, 1);
        check("s3_dv_count", dv_cnt, 2);
        check("s3_pdata_held", pdata, 8'h3C);

        presc = 6'd8;
        pen   = 1'b0;
        rx    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("s4_glitch_no_pulse", dv_cnt + pe_cnt + se_cnt, 4);
        send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 99, s);
        repeat (5) @(posedge clk);
        #1;
        check("s4_pdata", pdata, 8'h55);

        send_frame(8, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 99, s1);
        send_frame(8, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 99, s2);
        send_frame(8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 99, s3);
        repeat (5) @(posedge clk);
        #1;
        check("s5_dv_count", dv_cnt, 6);
        d1 = (dv_cyc.size() >= 6) ? dv_cyc[4] - dv_cyc[3] : -1;
        d2 = (dv_cyc.size() >= 6) ? dv_cyc[5] - dv_cyc[4] : -1;
        check("s5_spacing_1", d1, 80);
        check("s5_spacing_2", d2, 80);
        check("s5_pdata", pdata, 8'hC3);

        send_frame(8, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 5, s);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("s6_rst_pdata", pdata, 8'h00);
        check("s6_rst_pulses", {dv, pe, se}, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("s6_no_pulse_after_rst", dv_cnt + pe_cnt + se_cnt, 8);
        send_frame(8, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 99, s);
        repeat (5) @(posedge clk);
        #1;
        check("s6_pdata", pdata, 8'h96);
        check("s6_dv_count", dv_cnt, 7);
        check("events_consumed", evq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
